// File: rtl/imem_loader.sv
// imem_loader: boot-time writer for the 16-bit instruction memory.
// Streams an image in over valid/ready, writes it from BASE_ADDR upward,
// reads it back to compare checksums, and keeps the fetch PC frozen until
// the image has been loaded and verified.
module imem_loader #(
    parameter int unsigned ADDR_W    = 20,
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned BASE_ADDR = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              src_valid,
    input  logic [DATA_W-1:0] src_data,
    input  logic              src_last,
    output logic              src_ready,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_wr_addr,
    output logic [DATA_W-1:0] mem_wr_data,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_rd_addr,
    input  logic [DATA_W-1:0] mem_rd_data,
    output logic              pc_hold,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [ADDR_W-1:0] word_count
);

    localparam logic [ADDR_W-1:0] L_BASE = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] L_TOP  = '1;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        VERIFY_RD,
        VERIFY_CMP,
        DONE,
        ERROR
    } state_t;

    state_t             r_state;
    logic [ADDR_W-1:0]  r_wr_ptr;
    logic [ADDR_W-1:0]  r_rd_ptr;
    logic [ADDR_W-1:0]  r_rd_cnt;
    logic [ADDR_W-1:0]  r_word_count;
    logic [DATA_W-1:0]  r_load_sum;
    logic [DATA_W-1:0]  r_ver_sum;
    logic               r_src_ready;
    logic               r_mem_wr;
    logic [ADDR_W-1:0]  r_mem_wr_addr;
    logic [DATA_W-1:0]  r_mem_wr_data;
    logic               r_mem_rd;
    logic [ADDR_W-1:0]  r_mem_rd_addr;
    logic               r_pc_hold;
    logic               r_busy;
    logic               r_done;
    logic               r_error;

    logic               w_hs;
    logic [DATA_W-1:0]  w_ver_next;
    logic [ADDR_W-1:0]  w_rd_ptr_next;
    logic [ADDR_W-1:0]  w_rd_cnt_next;

    assign w_hs          = src_valid & r_src_ready;
    assign w_ver_next    = r_ver_sum + mem_rd_data;
    assign w_rd_ptr_next = r_rd_ptr + 1'b1;
    assign w_rd_cnt_next = r_rd_cnt + 1'b1;

    // Loader FSM: all outputs are registered and updated alongside the state.
    // Write and read strobes default low so each is a single-cycle pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= IDLE;
            r_wr_ptr      <= L_BASE;
            r_rd_ptr      <= L_BASE;
            r_rd_cnt      <= '0;
            r_word_count  <= '0;
            r_load_sum    <= '0;
            r_ver_sum     <= '0;
            r_src_ready   <= 1'b0;
            r_mem_wr      <= 1'b0;
            r_mem_wr_addr <= L_BASE;
            r_mem_wr_data <= '0;
            r_mem_rd      <= 1'b0;
            r_mem_rd_addr <= L_BASE;
            r_pc_hold     <= 1'b1;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_error       <= 1'b0;
        end else begin
            r_mem_wr <= 1'b0;
            r_mem_rd <= 1'b0;
            case (r_state)
                IDLE, DONE, ERROR: begin
                    if (start) begin
                        r_state      <= LOAD;
                        r_wr_ptr     <= L_BASE;
                        r_word_count <= '0;
                        r_load_sum   <= '0;
                        r_ver_sum    <= '0;
                        r_src_ready  <= 1'b1;
                        r_busy       <= 1'b1;
                        r_pc_hold    <= 1'b1;
                        r_done       <= 1'b0;
                        r_error      <= 1'b0;
                    end
                end

                LOAD: begin
                    if (w_hs) begin
                        r_mem_wr      <= 1'b1;
                        r_mem_wr_addr <= r_wr_ptr;
                        r_mem_wr_data <= src_data;
                        r_wr_ptr      <= r_wr_ptr + 1'b1;
                        r_word_count  <= r_word_count + 1'b1;
                        r_load_sum    <= r_load_sum + src_data;
                        if (src_last) begin
                            // Present the first read address as we enter
                            // VERIFY_RD so mem_rd is high during that state.
                            r_state       <= VERIFY_RD;
                            r_src_ready   <= 1'b0;
                            r_rd_ptr      <= L_BASE;
                            r_rd_cnt      <= '0;
                            r_mem_rd      <= 1'b1;
                            r_mem_rd_addr <= L_BASE;
                        end else if (r_wr_ptr == L_TOP) begin
                            r_state     <= ERROR;
                            r_src_ready <= 1'b0;
                            r_busy      <= 1'b0;
                            r_error     <= 1'b1;
                        end
                    end
                end

                VERIFY_RD: begin
                    r_state <= VERIFY_CMP;
                end

                VERIFY_CMP: begin
                    r_ver_sum <= w_ver_next;
                    r_rd_ptr  <= w_rd_ptr_next;
                    r_rd_cnt  <= w_rd_cnt_next;
                    if (w_rd_cnt_next == r_word_count) begin
                        r_busy <= 1'b0;
                        if (w_ver_next == r_load_sum) begin
                            r_state   <= DONE;
                            r_done    <= 1'b1;
                            r_pc_hold <= 1'b0;
                        end else begin
                            r_state <= ERROR;
                            r_error <= 1'b1;
                        end
                    end else begin
                        r_state       <= VERIFY_RD;
                        r_mem_rd      <= 1'b1;
                        r_mem_rd_addr <= w_rd_ptr_next;
                    end
                end

                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign src_ready   = r_src_ready;
    assign mem_wr      = r_mem_wr;
    assign mem_wr_addr = r_mem_wr_addr;
    assign mem_wr_data = r_mem_wr_data;
    assign mem_rd      = r_mem_rd;
    assign mem_rd_addr = r_mem_rd_addr;
    assign pc_hold     = r_pc_hold;
    assign busy        = r_busy;
    assign done        = r_done;
    assign error       = r_error;
    assign word_count  = r_word_count;

endmodule
